// File: rtl/pipe_stage_hs_pkg.sv
// Shared types and helpers for the handshaked pipeline-stage register.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY,
        ONE,
        FULL
    } state_t;

    localparam int unsigned CTRL_REGWRITE = 0;
    localparam int unsigned CTRL_MEMREAD  = 1;
    localparam int unsigned CTRL_MEMWRITE = 2;
    localparam int unsigned CTRL_MEMTOREG = 3;

    // Packed layout is {data, waddr, ctrl}, ctrl in the least significant bits.
    function automatic int unsigned bundle_w(input int unsigned lanes,
                                             input int unsigned data_w,
                                             input int unsigned addr_w,
                                             input int unsigned ctrl_w);
        return lanes * data_w + addr_w + ctrl_w;
    endfunction

endpackage

// File: rtl/pipe_stage_hs_slot.sv
// One bundle-wide storage entry: loads on enable, clears on async active-low reset.
module pipe_slot #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipe_stage_hs.sv
// Valid/ready pipeline-stage register with optional two-entry skid buffer,
// synchronous flush, bubble-gated control and a saturating stall counter.
module pipe_stage_hs
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned LANES  = 2,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned CTRL_W = 4,
    parameter int unsigned SKID   = 1,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES*DATA_W-1:0] in_data,
    input  logic [ADDR_W-1:0]       in_waddr,
    input  logic [CTRL_W-1:0]       in_ctrl,
    input  logic                    flush,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES*DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0]       out_waddr,
    output logic [CTRL_W-1:0]       out_ctrl,
    output logic [CNT_W-1:0]        stall_cycles
);

    localparam int unsigned BW = bundle_w(LANES, DATA_W, ADDR_W, CTRL_W);

    state_t            state;
    logic [BW-1:0]     in_bundle;
    logic [BW-1:0]     main_d;
    logic [BW-1:0]     main_q;
    logic [BW-1:0]     skid_q;
    logic [CTRL_W-1:0] held_ctrl;
    logic              in_xfer;
    logic              out_xfer;
    logic              main_load;
    logic              skid_load;

    assign in_bundle = {in_data, in_waddr, in_ctrl};
    assign out_valid = (state != EMPTY);
    assign in_xfer   = in_valid && in_ready;
    assign out_xfer  = out_valid && out_ready;

    generate
        if (SKID != 0) begin : g_ready_reg
            assign in_ready = (state != FULL);
        end else begin : g_ready_comb
            assign in_ready = !out_valid || out_ready;
        end
    endgenerate

    // Main slot is always the head; on a FULL drain it is refilled from the skid.
    always_comb begin
        main_d    = in_bundle;
        main_load = 1'b0;
        skid_load = 1'b0;
        if (SKID != 0) begin
            unique case (state)
                EMPTY: main_load = in_xfer;
                ONE: begin
                    main_load = in_xfer && out_xfer;
                    skid_load = in_xfer && !out_xfer;
                end
                FULL: begin
                    main_load = out_xfer;
                    main_d    = skid_q;
                end
                default: ;
            endcase
        end else begin
            main_load = in_xfer;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= EMPTY;
        end else if (flush) begin
            state <= EMPTY;
        end else if (SKID != 0) begin
            unique case (state)
                EMPTY: if (in_xfer) state <= ONE;
                ONE: begin
                    if (in_xfer && !out_xfer)      state <= FULL;
                    else if (!in_xfer && out_xfer) state <= EMPTY;
                end
                FULL: if (out_xfer) state <= ONE;
                default: state <= EMPTY;
            endcase
        end else if (in_xfer) begin
            state <= ONE;
        end else if (out_xfer) begin
            state <= EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cycles <= '0;
        end else if (out_valid && !out_ready && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + 1'b1;
        end
    end

    pipe_slot #(.W(BW)) u_main (
        .clk  (clk),
        .rst  (rst),
        .load (main_load),
        .d    (main_d),
        .q    (main_q)
    );

    generate
        if (SKID != 0) begin : g_skid
            pipe_slot #(.W(BW)) u_skid (
                .clk  (clk),
                .rst  (rst),
                .load (skid_load),
                .d    (in_bundle),
                .q    (skid_q)
            );
        end else begin : g_no_skid
            assign skid_q = '0;
        end
    endgenerate

    assign {out_data, out_waddr, held_ctrl} = main_q;
    assign out_ctrl = held_ctrl & {CTRL_W{out_valid}};

endmodule

// File: tb/tb_pipe_stage_hs.sv
// Bench for pipe_stage_hs: a SKID=1 / CNT_W=4 instance and a SKID=0 instance,
// both checked against queue-based reference models of a 2-deep and 1-deep FIFO.
module tb_pipe_stage_hs;
    import pipe_pkg::*;

    localparam int unsigned DW = 32;
    localparam int unsigned LN = 2;
    localparam int unsigned AW = 5;
    localparam int unsigned CW = 4;
    localparam int unsigned BW = bundle_w(LN, DW, AW, CW);
    typedef logic [BW-1:0] bundle_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic            iv0, ir0, fl0, ov0, or0;
    logic [LN*DW-1:0] id0, od0;
    logic [AW-1:0]   ia0, oa0;
    logic [CW-1:0]   ic0, oc0;
    logic [3:0]      st0;

    logic            iv1, ir1, fl1, ov1, or1;
    logic [LN*DW-1:0] id1, od1;
    logic [AW-1:0]   ia1, oa1;
    logic [CW-1:0]   ic1, oc1;
    logic [15:0]     st1;

    pipe_stage_hs #(.DATA_W(DW), .LANES(LN), .ADDR_W(AW), .CTRL_W(CW), .SKID(1), .CNT_W(4)) dut0 (
        .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(ir0), .in_data(id0), .in_waddr(ia0),
        .in_ctrl(ic0), .flush(fl0), .out_valid(ov0), .out_ready(or0), .out_data(od0),
        .out_waddr(oa0), .out_ctrl(oc0), .stall_cycles(st0)
    );

    pipe_stage_hs #(.DATA_W(DW), .LANES(LN), .ADDR_W(AW), .CTRL_W(CW), .SKID(0), .CNT_W(16)) dut1 (
        .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .in_data(id1), .in_waddr(ia1),
        .in_ctrl(ic1), .flush(fl1), .out_valid(ov1), .out_ready(or1), .out_data(od1),
        .out_waddr(oa1), .out_ctrl(oc1), .stall_cycles(st1)
    );

    bundle_t     q0[$];
    bundle_t     q1[$];
    int unsigned cnt0, cnt1;
    int unsigned checks, errors;

    // Advance one clock and update both reference FIFOs from the inputs seen at the edge.
    task automatic tick();
        bit in0, out0, stl0, in1, out1, stl1;
        in0  = iv0 && (q0.size() < 2);
        out0 = (q0.size() != 0) && or0;
        stl0 = (q0.size() != 0) && !or0;
        in1  = iv1 && ((q1.size() == 0) || or1);
        out1 = (q1.size() != 0) && or1;
        stl1 = (q1.size() != 0) && !or1;
        @(posedge clk);
        if (rst) begin
            if (stl0 && cnt0 < 15)    cnt0++;
            if (stl1 && cnt1 < 65535) cnt1++;
            if (fl0) q0.delete();
            else begin
                if (out0) void'(q0.pop_front());
                if (in0)  q0.push_back({id0, ia0, ic0});
            end
            if (fl1) q1.delete();
            else begin
                if (out1) void'(q1.pop_front());
                if (in1)  q1.push_back({id1, ia1, ic1});
            end
        end
        #1;
    endtask

    task automatic model_clear();
        q0.delete();
        q1.delete();
        cnt0 = 0;
        cnt1 = 0;
    endtask

    task automatic rand_bundle(output logic [LN*DW-1:0] d, output logic [AW-1:0] a,
                               output logic [CW-1:0] c);
        d = {$urandom, $urandom};
        a = AW'($urandom);
        c = CW'($urandom);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        iv0 = 0; fl0 = 0; or0 = 0; id0 = '0; ia0 = '0; ic0 = '0;
        iv1 = 0; fl1 = 0; or1 = 0; id1 = '0; ia1 = '0; ic1 = '0;
        model_clear();
        repeat (2) @(negedge clk);
        checks++; if (ov0 !== 1'b0) begin errors++; $display("FAIL reset_valid0: got %b exp 0", ov0); end
        checks++; if (ir0 !== 1'b1) begin errors++; $display("FAIL reset_ready0: got %b exp 1", ir0); end
        checks++; if ({od0, oa0, oc0} !== '0) begin errors++; $display("FAIL reset_fields0: got %h exp 0", {od0, oa0, oc0}); end
        checks++; if (st0 !== 4'd0) begin errors++; $display("FAIL reset_stall0: got %h exp 0", st0); end
        checks++; if (ov1 !== 1'b0) begin errors++; $display("FAIL reset_valid1: got %b exp 0", ov1); end
        checks++; if (ir1 !== 1'b1) begin errors++; $display("FAIL reset_ready1: got %b exp 1", ir1); end
        checks++; if (st1 !== 16'd0) begin errors++; $display("FAIL reset_stall1: got %h exp 0", st1); end
        rst = 1'b1;
        or1 = 1'b1;
    endtask

    task automatic test_single();
        iv0 = 1; id0 = {32'h0000_0010, 32'hDEAD_BEEF}; ia0 = 5'd7; ic0 = 4'b0001; or0 = 1;
        #2;
        checks++; if (ir0 !== 1'b1) begin errors++; $display("FAIL single_ready: got %b exp 1", ir0); end
        tick();
        iv0 = 0;
        #2;
        checks++; if (ov0 !== 1'b1) begin errors++; $display("FAIL single_valid: got %b exp 1", ov0); end
        checks++; if (od0 !== 64'h0000_0010_DEAD_BEEF) begin errors++; $display("FAIL single_data: got %h exp 0000_0010_DEAD_BEEF", od0); end
        checks++; if (oa0 !== 5'd7) begin errors++; $display("FAIL single_waddr: got %0d exp 7", oa0); end
        checks++; if (oc0 !== 4'b0001) begin errors++; $display("FAIL single_ctrl: got %b exp 0001", oc0); end
        tick();
        #2;
        checks++; if (ov0 !== 1'b0) begin errors++; $display("FAIL single_drain_valid: got %b exp 0", ov0); end
        checks++; if (oc0 !== 4'b0000) begin errors++; $display("FAIL single_bubble_ctrl: got %b exp 0000", oc0); end
        checks++; if (oc0[CTRL_REGWRITE] !== 1'b0 || oc0[CTRL_MEMWRITE] !== 1'b0) begin
            errors++; $display("FAIL single_bubble_wr: got %b exp 0000", oc0);
        end
    endtask

    task automatic test_backpressure();
        bundle_t     sent[3];
        bundle_t     got[$];
        int unsigned base;
        bit          acc;
        logic [LN*DW-1:0] d; logic [AW-1:0] a; logic [CW-1:0] c;
        base = cnt0;
        or0 = 0;
        for (int i = 0; i < 3; i++) begin
            rand_bundle(d, a, c);
            sent[i] = {d, a, c};
        end
        iv0 = 1; {id0, ia0, ic0} = sent[0];
        tick();
        {id0, ia0, ic0} = sent[1];
        #2;
        checks++; if (ir0 !== 1'b1) begin errors++; $display("FAIL bp_ready_b: got %b exp 1", ir0); end
        checks++; if ({od0, oa0, oc0} !== sent[0]) begin errors++; $display("FAIL bp_head_a: got %h exp %h", {od0, oa0, oc0}, sent[0]); end
        tick();
        {id0, ia0, ic0} = sent[2];
        #2;
        checks++; if (ir0 !== 1'b0) begin errors++; $display("FAIL bp_ready_full: got %b exp 0", ir0); end
        tick();
        #2;
        checks++; if (ir0 !== 1'b0) begin errors++; $display("FAIL bp_c_refused: got %b exp 0", ir0); end
        checks++; if ({od0, oa0, oc0} !== sent[0]) begin errors++; $display("FAIL bp_head_held: got %h exp %h", {od0, oa0, oc0}, sent[0]); end
        checks++; if (st0 !== 4'((base + 2 > 15) ? 15 : base + 2)) begin
            errors++; $display("FAIL bp_stall_count: got %0d exp %0d", st0, (base + 2 > 15) ? 15 : base + 2);
        end
        or0 = 1;
        for (int i = 0; i < 8; i++) begin
            #2;
            if (ov0) got.push_back({od0, oa0, oc0});
            acc = iv0 && ir0;
            tick();
            if (acc) iv0 = 0;
        end
        checks++; if (got.size() != 3) begin errors++; $display("FAIL bp_delivered: got %0d exp 3", got.size()); end
        for (int i = 0; i < 3; i++) begin
            if (i < got.size()) begin
                checks++; if (got[i] !== sent[i]) begin errors++; $display("FAIL bp_order%0d: got %h exp %h", i, got[i], sent[i]); end
            end
        end
    endtask

    task automatic test_flush();
        logic [LN*DW-1:0] d; logic [AW-1:0] a; logic [CW-1:0] c;
        or0 = 0; iv0 = 1; fl0 = 0;
        rand_bundle(d, a, c); {id0, ia0, ic0} = {d, a, c};
        tick();
        rand_bundle(d, a, c); {id0, ia0, ic0} = {d, a, c};
        tick();
        rand_bundle(d, a, c); {id0, ia0, ic0} = {d, a, c};
        fl0 = 1;
        #2;
        checks++; if (ir0 !== 1'b0) begin errors++; $display("FAIL flush_full_ready: got %b exp 0", ir0); end
        tick();
        fl0 = 0; iv0 = 0;
        #2;
        checks++; if (ov0 !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b exp 0", ov0); end
        checks++; if (ir0 !== 1'b1) begin errors++; $display("FAIL flush_ready: got %b exp 1", ir0); end
        checks++; if (oc0 !== 4'b0000) begin errors++; $display("FAIL flush_ctrl: got %b exp 0000", oc0); end
        iv0 = 1; rand_bundle(d, a, c); {id0, ia0, ic0} = {d, a, c};
        tick();
        rand_bundle(d, a, c); {id0, ia0, ic0} = {d, a, c}; ic0 = 4'b1111;
        fl0 = 1;
        #2;
        checks++; if (ir0 !== 1'b1) begin errors++; $display("FAIL flush_one_ready: got %b exp 1", ir0); end
        tick();
        iv0 = 0; fl0 = 0; or0 = 1;
        for (int i = 0; i < 3; i++) begin
            #2;
            checks++; if (ov0 !== 1'b0 || oc0 !== 4'b0000) begin
                errors++; $display("FAIL flush_dropped%0d: got valid=%b ctrl=%b exp 0/0000", i, ov0, oc0);
            end
            tick();
        end
    endtask

    task automatic test_skid0();
        bundle_t prev;
        iv0 = 0; or0 = 1; fl0 = 0;
        iv1 = 1; or1 = 1; fl1 = 0;
        prev = '0;
        for (int i = 0; i < 8; i++) begin
            rand_bundle(id1, ia1, ic1);
            #2;
            checks++; if (ir1 !== 1'b1) begin errors++; $display("FAIL s0_ready%0d: got %b exp 1", i, ir1); end
            if (i > 0) begin
                checks++; if (ov1 !== 1'b1 || {od1, oa1, oc1} !== prev) begin
                    errors++; $display("FAIL s0_thru%0d: got %b/%h exp 1/%h", i, ov1, {od1, oa1, oc1}, prev);
                end
            end
            prev = {id1, ia1, ic1};
            tick();
        end
        or1 = 0;
        #2;
        checks++; if (ir1 !== 1'b0) begin errors++; $display("FAIL s0_comb_ready_low: got %b exp 0", ir1); end
        or1 = 1;
        #1;
        checks++; if (ir1 !== 1'b1) begin errors++; $display("FAIL s0_comb_ready_high: got %b exp 1", ir1); end
        iv1 = 0;
        tick();
        tick();
    endtask

    task automatic test_saturation();
        bundle_t held;
        logic [LN*DW-1:0] d; logic [AW-1:0] a; logic [CW-1:0] c;
        rand_bundle(d, a, c);
        held = {d, a, c};
        iv0 = 1; or0 = 0; {id0, ia0, ic0} = held;
        tick();
        iv0 = 0;
        repeat (20) tick();
        #2;
        checks++; if (st0 !== 4'hF) begin errors++; $display("FAIL sat_stall: got %h exp f", st0); end
        checks++; if (ov0 !== 1'b1 || {od0, oa0, oc0} !== held) begin
            errors++; $display("FAIL sat_head: got %b/%h exp 1/%h", ov0, {od0, oa0, oc0}, held);
        end
        or0 = 1;
        tick();
    endtask

    task automatic test_async_reset();
        logic [LN*DW-1:0] d; logic [AW-1:0] a; logic [CW-1:0] c;
        or0 = 0; iv0 = 1;
        rand_bundle(d, a, c); {id0, ia0, ic0} = {d, a, c}; ic0 = 4'b0101;
        tick();
        rand_bundle(d, a, c); {id0, ia0, ic0} = {d, a, c};
        tick();
        iv0 = 0;
        tick();
        #2;
        rst = 1'b0;
        model_clear();
        #1;
        checks++; if (ov0 !== 1'b0) begin errors++; $display("FAIL areset_valid: got %b exp 0", ov0); end
        checks++; if (oc0 !== 4'b0000) begin errors++; $display("FAIL areset_ctrl: got %b exp 0000", oc0); end
        checks++; if (st0 !== 4'd0) begin errors++; $display("FAIL areset_stall: got %h exp 0", st0); end
        checks++; if (ir0 !== 1'b1) begin errors++; $display("FAIL areset_ready: got %b exp 1", ir0); end
        checks++; if (od0 !== '0) begin errors++; $display("FAIL areset_data: got %h exp 0", od0); end
        #1;
        rst = 1'b1;
    endtask

    task automatic test_random();
        bit hold0, hold1;
        hold0 = 0; hold1 = 0;
        for (int n = 0; n < 400; n++) begin
            if (!hold0) begin
                iv0 = ($urandom_range(0, 3) != 0);
                rand_bundle(id0, ia0, ic0);
            end
            if (!hold1) begin
                iv1 = ($urandom_range(0, 3) != 0);
                rand_bundle(id1, ia1, ic1);
            end
            or0 = ($urandom_range(0, 9) < 5);
            or1 = ($urandom_range(0, 9) < 6);
            fl0 = ($urandom_range(0, 19) == 0);
            fl1 = ($urandom_range(0, 19) == 0);
            #2;
            checks++; if (ov0 !== (q0.size() != 0)) begin errors++; $display("FAIL rnd0_valid@%0d: got %b exp %b", n, ov0, q0.size() != 0); end
            checks++; if (ir0 !== (q0.size() < 2)) begin errors++; $display("FAIL rnd0_ready@%0d: got %b exp %b", n, ir0, q0.size() < 2); end
            checks++; if (st0 !== 4'(cnt0)) begin errors++; $display("FAIL rnd0_stall@%0d: got %0d exp %0d", n, st0, cnt0); end
            checks++;
            if (q0.size() != 0) begin
                if ({od0, oa0, oc0} !== q0[0]) begin errors++; $display("FAIL rnd0_head@%0d: got %h exp %h", n, {od0, oa0, oc0}, q0[0]); end
            end else if (oc0 !== '0) begin
                errors++; $display("FAIL rnd0_bubble@%0d: got %b exp 0000", n, oc0);
            end
            checks++; if (ov1 !== (q1.size() != 0)) begin errors++; $display("FAIL rnd1_valid@%0d: got %b exp %b", n, ov1, q1.size() != 0); end
            checks++; if (ir1 !== ((q1.size() == 0) || or1)) begin errors++; $display("FAIL rnd1_ready@%0d: got %b exp %b", n, ir1, (q1.size() == 0) || or1); end
            checks++; if (st1 !== 16'(cnt1)) begin errors++; $display("FAIL rnd1_stall@%0d: got %0d exp %0d", n, st1, cnt1); end
            checks++;
            if (q1.size() != 0) begin
                if ({od1, oa1, oc1} !== q1[0]) begin errors++; $display("FAIL rnd1_head@%0d: got %h exp %h", n, {od1, oa1, oc1}, q1[0]); end
            end else if (oc1 !== '0) begin
                errors++; $display("FAIL rnd1_bubble@%0d: got %b exp 0000", n, oc1);
            end
            hold0 = iv0 && !(q0.size() < 2);
            hold1 = iv1 && !((q1.size() == 0) || or1);
            tick();
        end
        iv0 = 0; iv1 = 0; fl0 = 0; fl1 = 0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_single();
        test_backpressure();
        test_flush();
        test_skid0();
        test_saturation();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
